axi_aw_w_sync: RTL and testbench
================================

Name: axi_aw_w_sync

Overview:
- Write-channel ordering stage placed directly downstream of the AW and W axi_buffer FIFOs, in front of the slave port.
- Forwards AW requests and releases W beats only for bursts whose AW has already been accepted downstream.
- Tracks each accepted burst's length in an internal length FIFO and regenerates WLAST from a beat counter.
- Flags any mismatch between the upstream WLAST and the generated WLAST.

Parameters:
- AW_WIDTH, 64, width of the packed AW payload (addr/id/size/burst/...), excluding len.
- W_WIDTH, 37, width of the packed W payload (data+strb+user), excluding last.
- MAX_OUTSTANDING, 4, depth of the length FIFO (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_valid_i  in  1  AW from upstream buffer valid
- aw_data_i  in  AW_WIDTH  AW payload
- aw_len_i  in  8  AXI4 burst length (beats-1)
- aw_ready_o  out  1  AW accept to upstream buffer
- aw_valid_o  out  1  AW to slave valid
- aw_data_o  out  AW_WIDTH  AW payload to slave
- aw_len_o  out  8  burst length to slave
- aw_ready_i  in  1  slave AW ready
- w_valid_i  in  1  W from upstream buffer valid
- w_data_i  in  W_WIDTH  W payload
- w_last_i  in  1  upstream WLAST (checked only)
- w_ready_o  out  1  W accept to upstream buffer
- w_valid_o  out  1  W to slave valid
- w_data_o  out  W_WIDTH  W payload to slave
- w_last_o  out  1  generated WLAST
- w_ready_i  in  1  slave W ready
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  bursts accepted with W not yet complete
- err_o  out  1  one-cycle pulse on WLAST mismatch

Behaviour:
- One clock clk_i; reset rst_ni is asynchronous, active-low. Reset clears: length FIFO (pointers, count = 0), beat_cnt = 0, err_o = 0.
- Immediately after reset: aw_valid_o = aw_valid_i, w_valid_o = 0, w_ready_o = 0, outstanding_o = 0.
- Datapath is zero latency; aw_data_o/aw_len_o/w_data_o are direct pass-through. No payload is registered.
- len_full = (count == MAX_OUTSTANDING); len_empty = (count == 0). Both are derived from registered state only.
- AW gating:
  - aw_valid_o = aw_valid_i & !len_full
  - aw_ready_o = aw_ready_i & !len_full
- AW handshake (aw_valid_o & aw_ready_i) pushes aw_len_i into the length FIFO.
- W gating:
  - w_valid_o = w_valid_i & !len_empty
  - w_ready_o = w_ready_i & !len_empty
- W handshake (w_valid_o & w_ready_i):
  - if beat_cnt == head_len: pop the FIFO and set beat_cnt = 0
  - else: beat_cnt = beat_cnt + 1 (8-bit; cannot overflow because head_len <= 255)
- w_last_o = !len_empty & (beat_cnt == head_len).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: push is blocked even if a pop occurs in the same cycle (no bypass).
- Empty: a W beat is not accepted in the same cycle as the first AW push; it is accepted from the next cycle.
- Pointers wrap from MAX_OUTSTANDING-1 to 0.
- err_o is registered; it equals 1 in the cycle after a W handshake where w_last_i != w_last_o.
  - The generated w_last_o is authoritative; the beat is still forwarded and counting continues on the generated value.
- outstanding_o = count.
- Reset asserted mid-burst: all state clears immediately (asynchronously); partial bursts are discarded, with no recovery.
- len = 0 bursts: single beat, w_last_o = 1 on that beat.

Test Plan:
- Reset, then W beat offered with no AW -> w_ready_o = 0, w_valid_o = 0 for 10 cycles; outstanding_o = 0.
- AW len=3 accepted at cycle N, 4 W beats with w_ready_i = 1 -> beats accepted from N+1; w_last_o = 1 on 4th beat only; outstanding_o 1 -> 0 after 4th beat; err_o = 0.
- 5 AWs (len=0) with w_valid_i = 0, MAX_OUTSTANDING=4 -> first 4 accepted; 5th sees aw_ready_o = 0 and aw_valid_o = 0; outstanding_o = 4.
- Then one W beat accepted in the same cycle the 5th AW is offered -> 5th AW is still blocked that cycle and accepted next cycle; outstanding_o stays 4.
- AW len=1, upstream W with w_last_i = 1 on beat 0 -> w_last_o = 0 on beat 0; err_o = 1 for exactly one cycle after; burst completes on beat 1.
- Back-to-back AW len=0 and len=2 with continuous W and w_ready_i toggling 1/0 -> beat order preserved; w_last_o asserted on beats 1 and 4 overall.
- Reset asserted after 2 of 4 beats -> outstanding_o = 0 and w_ready_o = 0 immediately; after release, a new AW len=0 plus one beat completes with w_last_o = 1.

Source files
------------

// File: rtl/axi_aw_w_sync.sv
// axi_aw_w_sync: AXI write-channel ordering stage.
// Forwards AW requests, releases W beats only for bursts whose AW has been
// accepted downstream, regenerates WLAST from a per-burst beat counter and
// flags upstream WLAST mismatches.
module axi_aw_w_sync #(
  parameter int unsigned AW_WIDTH        = 64,
  parameter int unsigned W_WIDTH         = 37,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  // AW from upstream buffer
  input  logic                               aw_valid_i,
  input  logic [AW_WIDTH-1:0]                aw_data_i,
  input  logic [7:0]                         aw_len_i,
  output logic                               aw_ready_o,
  // AW to slave
  output logic                               aw_valid_o,
  output logic [AW_WIDTH-1:0]                aw_data_o,
  output logic [7:0]                         aw_len_o,
  input  logic                               aw_ready_i,
  // W from upstream buffer
  input  logic                               w_valid_i,
  input  logic [W_WIDTH-1:0]                 w_data_i,
  input  logic                               w_last_i,
  output logic                               w_ready_o,
  // W to slave
  output logic                               w_valid_o,
  output logic [W_WIDTH-1:0]                 w_data_o,
  output logic                               w_last_o,
  input  logic                               w_ready_i,
  // status
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    len_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    beat_cnt_q;
  logic          err_q;

  logic          len_full, len_empty;
  logic [7:0]    head_len;
  logic          beat_is_last;
  logic          push, w_hs, pop;

  // Status flags come from registered state only, so the full case never
  // bypasses a same-cycle pop and the empty case never bypasses a push.
  always_comb begin
    len_full     = (count_q == CW'(MAX_OUTSTANDING));
    len_empty    = (count_q == '0);
    head_len     = len_mem[rd_ptr_q];
    beat_is_last = (beat_cnt_q == head_len);

    aw_valid_o   = aw_valid_i & ~len_full;
    aw_ready_o   = aw_ready_i & ~len_full;
    aw_data_o    = aw_data_i;
    aw_len_o     = aw_len_i;

    w_valid_o    = w_valid_i & ~len_empty;
    w_ready_o    = w_ready_i & ~len_empty;
    w_data_o     = w_data_i;
    w_last_o     = ~len_empty & beat_is_last;

    push         = aw_valid_o & aw_ready_i;
    w_hs         = w_valid_o & w_ready_i;
    pop          = w_hs & beat_is_last;

    outstanding_o = count_q;
    err_o         = err_q;
  end

  // Length storage: written on every accepted AW, no reset needed since
  // entries are only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      len_mem[wr_ptr_q] <= aw_len_i;
    end
  end

  // Length FIFO pointers and occupancy; pointers wrap naturally at the
  // power-of-two depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Beat counter for the head burst; the generated last is authoritative.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
    end else if (w_hs) begin
      if (beat_is_last) beat_cnt_q <= '0;
      else              beat_cnt_q <= beat_cnt_q + 8'd1;
    end
  end

  // One-cycle error pulse after a beat whose upstream last disagrees.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= w_hs & (w_last_i != w_last_o);
    end
  end

endmodule

// File: tb/tb_axi_aw_w_sync.sv
// tb_axi_aw_w_sync: directed self-checking bench for axi_aw_w_sync.
module tb_axi_aw_w_sync;

  localparam int unsigned AW_WIDTH = 64;
  localparam int unsigned W_WIDTH  = 37;
  localparam int unsigned MAX_OUT  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic [AW_WIDTH-1:0] aw_data_i, aw_data_o;
  logic [7:0]          aw_len_i, aw_len_o;
  logic                w_valid_i, w_last_i, w_ready_o, w_valid_o, w_last_o, w_ready_i;
  logic [W_WIDTH-1:0]  w_data_i, w_data_o;
  logic [2:0]          outstanding;
  logic                err;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  axi_aw_w_sync #(
    .AW_WIDTH       (AW_WIDTH),
    .W_WIDTH        (W_WIDTH),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .aw_valid_i   (aw_valid_i),
    .aw_data_i    (aw_data_i),
    .aw_len_i     (aw_len_i),
    .aw_ready_o   (aw_ready_o),
    .aw_valid_o   (aw_valid_o),
    .aw_data_o    (aw_data_o),
    .aw_len_o     (aw_len_o),
    .aw_ready_i   (aw_ready_i),
    .w_valid_i    (w_valid_i),
    .w_data_i     (w_data_i),
    .w_last_i     (w_last_i),
    .w_ready_o    (w_ready_o),
    .w_valid_o    (w_valid_o),
    .w_data_o     (w_data_o),
    .w_last_o     (w_last_o),
    .w_ready_i    (w_ready_i),
    .outstanding_o(outstanding),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_last [4];
    int unsigned idx, naw;
    logic hs_w, hs_aw;

    rst_n = 1'b0;
    aw_valid_i = 1'b1; aw_data_i = 64'h0123_4567_89ab_cdef; aw_len_i = 8'd0; aw_ready_i = 1'b0;
    w_valid_i = 1'b0; w_data_i = '0; w_last_i = 1'b0; w_ready_i = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    check("rst_aw_valid_follows", aw_valid_o, 1);
    check("rst_w_valid", w_valid_o, 0);
    check("rst_w_ready", w_ready_o, 0);
    rst_n = 1'b1;
    aw_valid_i = 1'b0;

    // W offered with no AW: never accepted
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_data_i = 37'h1_2345_6789;
    for (int i = 0; i < 10; i++) begin
      step();
      check("noaw_w_ready", w_ready_o, 0);
      check("noaw_w_valid", w_valid_o, 0);
      check("noaw_outstanding", outstanding, 0);
    end

    // AW len=3 then 4 beats
    aw_valid_i = 1'b1; aw_len_i = 8'd3; aw_ready_i = 1'b1;
    aw_data_i = 64'hdead_beef_cafe_f00d; w_last_i = 1'b0;
    #1;
    check("aw_pass_valid", aw_valid_o, 1);
    check("aw_pass_ready", aw_ready_o, 1);
    check("aw_pass_data", aw_data_o, 64'hdead_beef_cafe_f00d);
    check("aw_pass_len", aw_len_o, 3);
    check("w_blocked_on_push", w_ready_o, 0);
    step();
    aw_valid_i = 1'b0;
    check("len3_outstanding", outstanding, 1);
    for (int b = 0; b < 4; b++) begin
      w_data_i = 37'(b + 8'h10);
      w_last_i = (b == 3);
      #1;
      check("len3_w_valid", w_valid_o, 1);
      check("len3_w_data", w_data_o, 37'(b + 8'h10));
      check("len3_w_last", w_last_o, (b == 3));
      check("len3_outstanding_mid", outstanding, 1);
      step();
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    check("len3_done_outstanding", outstanding, 0);
    check("len3_err", err, 0);

    // fill the length FIFO with 5 len=0 AWs
    aw_valid_i = 1'b1; aw_len_i = 8'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fill_aw_ready", aw_ready_o, 1);
      step();
    end
    #1;
    check("full_outstanding", outstanding, 4);
    check("full_aw_ready", aw_ready_o, 0);
    check("full_aw_valid", aw_valid_o, 0);
    // pop in the same cycle: push still blocked
    w_valid_i = 1'b1; w_last_i = 1'b1;
    #1;
    check("full_pop_aw_ready", aw_ready_o, 0);
    check("full_pop_w_last", w_last_o, 1);
    step();
    w_valid_i = 1'b0;
    #1;
    check("after_pop_outstanding", outstanding, 3);
    check("after_pop_aw_ready", aw_ready_o, 1);
    step();
    aw_valid_i = 1'b0;
    check("fifth_aw_outstanding", outstanding, 4);
    // drain through the wrapped pointers
    w_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_w_last", w_last_o, 1);
      step();
    end
    w_valid_i = 1'b0;
    check("drain_outstanding", outstanding, 0);
    check("drain_err", err, 0);

    // WLAST mismatch on a len=1 burst
    aw_valid_i = 1'b1; aw_len_i = 8'd1;
    step();
    aw_valid_i = 1'b0;
    w_valid_i = 1'b1; w_last_i = 1'b1;
    #1;
    check("mm_beat0_last", w_last_o, 0);
    check("mm_err_before", err, 0);
    step();
    check("mm_err_pulse", err, 1);
    check("mm_beat1_last", w_last_o, 1);
    step();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    check("mm_err_cleared", err, 0);
    check("mm_outstanding", outstanding, 0);

    // back-to-back len=0 and len=2 with toggling w_ready_i
    exp_last[0] = 1'b1; exp_last[1] = 1'b0; exp_last[2] = 1'b0; exp_last[3] = 1'b1;
    idx = 0; naw = 0;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      aw_valid_i = (naw < 2);
      aw_len_i   = (naw == 0) ? 8'd0 : 8'd2;
      w_valid_i  = 1'b1;
      w_ready_i  = (cyc % 2 == 0);
      w_data_i   = 37'(idx + 8'h40);
      w_last_i   = exp_last[idx];
      #1;
      hs_w  = w_valid_o & w_ready_i;
      hs_aw = aw_valid_o & aw_ready_i;
      if (hs_w) begin
        check("b2b_w_data", w_data_o, 37'(idx + 8'h40));
        check("b2b_w_last", w_last_o, exp_last[idx]);
      end
      step();
      if (hs_w)  idx++;
      if (hs_aw) naw++;
    end
    aw_valid_i = 1'b0; w_valid_i = 1'b0; w_ready_i = 1'b1; w_last_i = 1'b0;
    check("b2b_beats_done", idx, 4);
    check("b2b_outstanding", outstanding, 0);
    check("b2b_err", err, 0);

    // reset in the middle of a burst
    aw_valid_i = 1'b1; aw_len_i = 8'd3;
    step();
    aw_valid_i = 1'b0; w_valid_i = 1'b1;
    step();
    step();
    check("midrst_outstanding_before", outstanding, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outstanding", outstanding, 0);
    check("midrst_w_ready", w_ready_o, 0);
    w_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    aw_valid_i = 1'b1; aw_len_i = 8'd0;
    step();
    aw_valid_i = 1'b0; w_valid_i = 1'b1; w_last_i = 1'b1;
    #1;
    check("postrst_w_last", w_last_o, 1);
    check("postrst_w_ready", w_ready_o, 1);
    step();
    w_valid_i = 1'b0;
    check("postrst_outstanding", outstanding, 0);
    check("postrst_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
